// File: rtl/rv_core_pkg.sv
// Shared definitions for the RV32I core: fetch FSM encoding, NOP word,
// instruction field positions and the default reset PC.
package rv_core_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int OP_LSB = 0;
    localparam int OP_MSB = 6;
    localparam int F3_LSB = 12;
    localparam int F3_MSB = 14;
    localparam int F7_LSB = 25;
    localparam int F7_MSB = 31;

endpackage : rv_core_pkg

// File: rtl/pc_next_gen.sv
// Next-PC selection: sequential PC+4 (wrapping) or the downstream target,
// plus a flag when the chosen address is not word aligned.
module pc_next_gen #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            pc_src_i,
    input  logic [XLEN-1:0] pc_target_i,
    output logic [XLEN-1:0] next_pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            misalign_o
);

    // Select the successor PC; PC+4 silently wraps at 2^XLEN.
    always_comb begin
        pc_plus4_o = pc_i + XLEN'(4);
        if (pc_src_i) begin
            next_pc_o = pc_target_i;
        end else begin
            next_pc_o = pc_plus4_o;
        end
        misalign_o = |next_pc_o[1:0];
    end

endmodule : pc_next_gen

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the single-cycle RV32I core. Owns the PC and the
// instruction register, fetches one word per step over a req/ack port and
// holds it stable for decode until execute retires it.
module instr_fetch_unit
    import rv_core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    input  logic            retire,
    input  logic            stall,
    output logic            instr_valid,
    output logic [31:0]     Instr,
    output logic [6:0]      Op,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic            misaligned
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;
    logic            req_q;
    logic            valid_q;
    logic            misaligned_q;

    logic [XLEN-1:0] next_pc_s;
    logic [XLEN-1:0] pc_plus4_s;
    logic            misalign_s;

    pc_next_gen #(
        .XLEN (XLEN)
    ) u_pc_next_gen (
        .pc_i        (pc_q),
        .pc_src_i    (PCSrc),
        .pc_target_i (PCTarget),
        .next_pc_o   (next_pc_s),
        .pc_plus4_o  (pc_plus4_s),
        .misalign_o  (misalign_s)
    );

    // Fetch FSM with PC, instruction register and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_RESET;
            pc_q         <= RESET_PC;
            instr_q      <= NOP_INSTR;
            req_q        <= 1'b0;
            valid_q      <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    state_q <= ST_FETCH;
                    req_q   <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        state_q <= ST_EXEC;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    // stall has priority: retire is ignored while it is high
                    if (retire && !stall) begin
                        valid_q <= 1'b0;
                        if (misalign_s) begin
                            misaligned_q <= 1'b1;
                            state_q      <= ST_HALT;
                        end else begin
                            pc_q    <= next_pc_s;
                            state_q <= ST_FETCH;
                            req_q   <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_HALT;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign Instr       = instr_q;
    assign Op          = instr_q[OP_MSB:OP_LSB];
    assign funct3      = instr_q[F3_MSB:F3_LSB];
    assign funct7      = instr_q[F7_MSB:F7_LSB];
    assign PC          = pc_q;
    assign PCPlus4     = pc_plus4_s;
    assign misaligned  = misaligned_q;

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        retire;
    logic        stall;
    logic        instr_valid;
    logic [31:0] Instr;
    logic [6:0]  Op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        misaligned;

    int n_checks;
    int n_fail;

    instr_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .PCSrc       (PCSrc),
        .PCTarget    (PCTarget),
        .retire      (retire),
        .stall       (stall),
        .instr_valid (instr_valid),
        .Instr       (Instr),
        .Op          (Op),
        .funct3      (funct3),
        .funct7      (funct7),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .misaligned  (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // advance one clock and settle 1 time unit past the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        check_val("rst_req",   32'(imem_req), 32'd0);
        check_val("rst_valid", 32'(instr_valid), 32'd0);
        check_val("rst_mis",   32'(misaligned), 32'd0);
        check_val("rst_pc",    PC, 32'h0000_0000);
        check_val("rst_instr", Instr, 32'h0000_0013);
        rst_n = 1'b1;
    endtask

    // wait (bounded) for a request, check its address and wait time, then ack
    task automatic fetch_one(input logic [31:0] data, input logic [31:0] exp_addr, input int exp_wait);
        int cyc;
        cyc = 0;
        while (!imem_req && cyc < 20) begin
            step();
            cyc++;
        end
        check_val("req_wait", 32'(cyc), 32'(exp_wait));
        check_val("req_addr", imem_addr, exp_addr);
        imem_ack   = 1'b1;
        imem_rdata = data;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check_val("valid", 32'(instr_valid), 32'd1);
        check_val("instr", Instr, data);
        check_val("req_low", 32'(imem_req), 32'd0);
    endtask

    task automatic do_retire(input logic src, input logic [31:0] tgt);
        retire   = 1'b1;
        PCSrc    = src;
        PCTarget = tgt;
        step();
        retire   = 1'b0;
        PCSrc    = 1'b0;
        PCTarget = 32'h0;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        PCSrc      = 1'b0;
        PCTarget   = 32'h0;
        retire     = 1'b0;
        stall      = 1'b0;

        // 1: reset then first fetch
        do_reset();
        fetch_one(32'h0050_0093, 32'h0, 1);
        check_val("t1_op", 32'(Op), 32'h13);
        check_val("t1_f3", 32'(funct3), 32'd0);
        check_val("t1_f7", 32'(funct7), 32'd0);
        check_val("t1_pc", PC, 32'h0);
        check_val("t1_pc4", PCPlus4, 32'h4);

        // 2: sequential retires, zero-wait memory
        do_retire(1'b0, 32'h0);
        fetch_one(32'h4020_5233, 32'h4, 0);
        check_val("t2_op", 32'(Op), 32'h33);
        check_val("t2_f3", 32'(funct3), 32'd5);
        check_val("t2_f7", 32'(funct7), 32'h20);
        do_retire(1'b0, 32'hFFFF_FFF0);
        fetch_one(32'h0000_0013, 32'h8, 0);
        do_retire(1'b0, 32'h0);
        fetch_one(32'h0010_0113, 32'hC, 0);
        check_val("t2_pc", PC, 32'hC);

        // 3: taken target, then misaligned target halts
        do_retire(1'b1, 32'h0000_0040);
        fetch_one(32'h0000_0013, 32'h40, 0);
        do_retire(1'b1, 32'h0000_0042);
        check_val("t3_mis", 32'(misaligned), 32'd1);
        check_val("t3_valid", 32'(instr_valid), 32'd0);
        check_val("t3_pc", PC, 32'h40);
        for (int i = 0; i < 4; i++) begin
            imem_ack = 1'b1;
            step();
            check_val("t3_noreq", 32'(imem_req), 32'd0);
        end
        imem_ack = 1'b0;
        check_val("t3_sticky", 32'(misaligned), 32'd1);

        // 4: stall blocks retire; stray ack in EXEC ignored
        do_reset();
        fetch_one(32'h0050_0093, 32'h0, 1);
        stall      = 1'b1;
        retire     = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("t4_pc", PC, 32'h0);
            check_val("t4_instr", Instr, 32'h0050_0093);
            check_val("t4_req", 32'(imem_req), 32'd0);
        end
        imem_ack = 1'b0;
        stall    = 1'b0;
        step();
        retire   = 1'b0;
        check_val("t4_pc_adv", PC, 32'h4);
        check_val("t4_req_adv", 32'(imem_req), 32'd1);
        step();
        check_val("t4_once", PC, 32'h4);

        // 5: withheld ack, reset mid-wait, late ack ignored
        do_reset();
        step();
        for (int i = 0; i < 10; i++) begin
            step();
            check_val("t5_req", 32'(imem_req), 32'd1);
            check_val("t5_addr", imem_addr, 32'h0);
        end
        rst_n = 1'b0;
        step();
        check_val("t5_req_drop", 32'(imem_req), 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        step();
        rst_n = 1'b1;
        step();
        imem_ack = 1'b0;
        check_val("t5_late_valid", 32'(instr_valid), 32'd0);
        check_val("t5_late_instr", Instr, 32'h0000_0013);
        fetch_one(32'h0050_0093, 32'h0, 0);

        // 6: PC wrap at top of address space
        do_retire(1'b1, 32'hFFFF_FFFC);
        fetch_one(32'h0000_0013, 32'hFFFF_FFFC, 0);
        check_val("t6_pc4", PCPlus4, 32'h0);
        PCSrc    = 1'b1;
        PCTarget = 32'h0000_0102;
        step();
        check_val("t6_ignored", PC, 32'hFFFF_FFFC);
        do_retire(1'b0, 32'h0);
        fetch_one(32'h0000_0013, 32'h0, 0);
        check_val("t6_mis", 32'(misaligned), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_instr_fetch_unit
